ex_dmem_responder: RTL and testbench

- Data-memory responder on the memory side of the execute stage's load/store request interface.
- Accepts one load or store per handshake and applies byte, halfword or word lane masking.
- Returns sign- or zero-extended load data after a fixed, parameterised latency that models cache or memory wait states.
- Drives a hold request so the pipeline stalls while an access is in flight.

---
 rtl/ex_dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_ex_dmem_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_dmem_responder.sv
// Data-memory responder: one load/store per handshake, fixed-latency response, pipeline hold.
// Optional DMEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses with err_o instead of masking.
module ex_dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        hold_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW       = DEPTH_LOG2 + 2;
    localparam int unsigned Words    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [31:0]     wdata_q;
    logic            mis_q;
    logic [31:0]     rword_q;
    logic [31:0]     mem_q [Words];

    logic            accept;
    logic            misalign;
    logic [3:0]      be;
    logic [31:0]     wrep;
    logic [1:0]      lane;
    logic [31:0]     shifted;
    logic            unused_addr;

    assign accept      = (state_q == StIdle) && req_i;
    // Upper address bits alias onto the array.
    assign unused_addr = ^addr_i[31:AW];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((size_i == 2'b01) && addr_i[0]) ||
                      (size_i[1] && (addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= we_i;
            addr_q  <= addr_i[AW-1:0];
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            wdata_q <= wdata_i;
            mis_q   <= misalign;
        end
    end

    always_comb begin
        be   = 4'b1111;
        wrep = wdata_q;
        lane = 2'b00;
        unique case (size_q)
            2'b00: begin
                be   = 4'b0001 << addr_q[1:0];
                wrep = {4{wdata_q[7:0]}};
                lane = addr_q[1:0];
            end
            2'b01: begin
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_q[15:0]}};
                lane = {addr_q[1], 1'b0};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata_q;
                lane = 2'b00;
            end
        endcase
    end

    // Storage array and load word register are deliberately not reset.
    always_ff @(posedge clk) begin
        if ((state_q == StAccess) && !mis_q) begin
            if (we_q) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem_q[addr_q[AW-1:2]][8*i +: 8] <= wrep[8*i +: 8];
                    end
                end
            end else begin
                rword_q <= mem_q[addr_q[AW-1:2]];
            end
        end
    end

    assign shifted = rword_q >> {lane, 3'b000};

    always_comb begin
        ready_o  = (state_q == StIdle);
        hold_o   = (state_q == StWait) || (state_q == StAccess) ||
                   ((state_q == StIdle) && req_i);
        rvalid_o = (state_q == StResp);
        rdata_o  = 32'd0;
        err_o    = 1'b0;
        if (state_q == StResp) begin
            err_o = mis_q;
            if (!we_q && !mis_q) begin
                unique case (size_q)
                    2'b00:   rdata_o = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
                    2'b01:   rdata_o = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
                    default: rdata_o = shifted;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_dmem_responder.sv
// Directed self-checking bench for ex_dmem_responder (WAIT_CYCLES = 1).
module tb_ex_dmem_responder;

    localparam int unsigned W   = 1;
    localparam int          LAT = W + 2;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        hold_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    ex_dmem_responder #(
        .DEPTH_LOG2 (12),
        .WAIT_CYCLES(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .size_i    (size_i),
        .unsigned_i(unsigned_i),
        .wdata_i   (wdata_i),
        .ready_o   (ready_o),
        .hold_o    (hold_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request from IDLE; returns response data, error and latency in negedges (0 = timeout).
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        we_i       = we;
        addr_i     = addr;
        size_i     = size;
        unsigned_i = uns;
        wdata_i    = wdata;
        req_i      = 1'b1;
        @(posedge clk);
        #1 req_i = 1'b0;
        lat   = 0;
        rdata = 32'd0;
        err   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rvalid_o) begin
                lat   = k;
                rdata = rdata_o;
                err   = err_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({ready_o, hold_o, rvalid_o, err_o} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got rdy/hold/rv/err=%b expected 1000",
                     {ready_o, hold_o, rvalid_o, err_o});
        end
        checks++;
        if (rdata_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata got %h expected 00000000", rdata_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_access(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if (lat !== LAT || rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL word_store got lat=%0d rdata=%h err=%b expected lat=%0d 0 0",
                     lat, rd, er, LAT);
        end
        do_access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (lat !== LAT || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL word_load got lat=%0d rdata=%h err=%b expected lat=%0d DEADBEEF 0",
                     lat, rd, er, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int ph;
        logic exp_hold;
        @(negedge clk);
        we_i = 1'b0; addr_i = 32'h100; size_i = 2'b10; unsigned_i = 1'b0; wdata_i = 32'd0;
        req_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || hold_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_req got ready=%b hold=%b expected 1 1", ready_o, hold_o);
        end
        for (int k = 1; k <= 2 * (W + 3); k++) begin
            @(negedge clk);
            if (k == W + 4) req_i = 1'b0;
            #1;
            ph       = ((k - 1) % (W + 3)) + 1;
            exp_hold = (ph <= W + 1) || (ph == W + 3 && k == W + 3);
            checks++;
            if (ready_o !== (ph == W + 3) || hold_o !== exp_hold || rvalid_o !== (ph == W + 2)) begin
                errors++;
                $display("FAIL b2b_cycle%0d got rdy/hold/rv=%b%b%b expected %b%b%b", k,
                         ready_o, hold_o, rvalid_o, ph == W + 3, exp_hold, ph == W + 2);
            end
            if (ph == W + 2) begin
                checks++;
                if (rdata_o !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL b2b_rdata%0d got %h expected DEADBEEF", k, rdata_o);
                end
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] exp_rd;
        logic        exp_er;
        logic [31:0] exp_mem;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_rd = 32'd0; exp_er = 1'b1; exp_mem = 32'hDEADBEEF;
`else
        exp_rd = 32'hDEADBEEF; exp_er = 1'b0; exp_mem = 32'h0BADF00D;
`endif
        do_access(1'b0, 32'h102, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (lat !== LAT || rd !== exp_rd || er !== exp_er) begin
            errors++;
            $display("FAIL misalign_load got lat=%0d rdata=%h err=%b expected lat=%0d %h %b",
                     lat, rd, er, LAT, exp_rd, exp_er);
        end
        do_access(1'b1, 32'h102, 2'b10, 1'b0, 32'h0BADF00D, rd, er, lat);
        checks++;
        if (lat !== LAT || er !== exp_er) begin
            errors++;
            $display("FAIL misalign_store got lat=%0d err=%b expected lat=%0d err=%b",
                     lat, er, LAT, exp_er);
        end
        do_access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== exp_mem || er !== 1'b0) begin
            errors++;
            $display("FAIL misalign_mem got rdata=%h err=%b expected %h 0", rd, er, exp_mem);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] exp_tab [4];
        logic [31:0] addr_tab [4];
        logic [1:0]  size_tab [4];
        logic        uns_tab [4];
        do_access(1'b1, 32'h100, 2'b10, 1'b0, 32'h0, rd, er, lat);
        do_access(1'b1, 32'h103, 2'b00, 1'b0, 32'h12345680, rd, er, lat);
        addr_tab = '{32'h103, 32'h103, 32'h100, 32'h102};
        size_tab = '{2'b00, 2'b00, 2'b10, 2'b00};
        uns_tab  = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_tab  = '{32'hFFFFFF80, 32'h00000080, 32'h80000000, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, addr_tab[i], size_tab[i], uns_tab[i], 32'h0, rd, er, lat);
            checks++;
            if (rd !== exp_tab[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL byte_lane%0d got rdata=%h err=%b expected %h 0",
                         i, rd, er, exp_tab[i]);
            end
        end
    endtask

    task automatic test_halfword();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] exp_tab [7];
        logic [31:0] addr_tab [7];
        logic [1:0]  size_tab [7];
        logic        uns_tab [7];
        do_access(1'b1, 32'h200, 2'b10, 1'b0, 32'hAAAA5555, rd, er, lat);
        do_access(1'b1, 32'h202, 2'b01, 1'b0, 32'hFFFF1234, rd, er, lat);
        do_access(1'b0, 32'h202, 2'b01, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h00001234) begin
            errors++;
            $display("FAIL half_signed got %h expected 00001234", rd);
        end
        do_access(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h12345555) begin
            errors++;
            $display("FAIL half_word got %h expected 12345555", rd);
        end
        do_access(1'b1, 32'h200, 2'b01, 1'b0, 32'h00008001, rd, er, lat);
        addr_tab = '{32'h200, 32'h200, 32'h201, 32'h201, 32'h4200, 32'h200, 32'h203};
        size_tab = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01};
        uns_tab  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_tab  = '{32'hFFFF8001, 32'h00008001, 32'h00000080, 32'hFFFFFF80,
                     32'h12348001, 32'h12348001, 32'h00001234};
        for (int i = 0; i < 7; i++) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (i == 6) break;
`endif
            do_access(1'b0, addr_tab[i], size_tab[i], uns_tab[i], 32'h0, rd, er, lat);
            checks++;
            if (rd !== exp_tab[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL half_vec%0d got rdata=%h err=%b expected %h 0",
                         i, rd, er, exp_tab[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;
        do_access(1'b1, 32'h300, 2'b10, 1'b0, 32'h11223344, rd, er, lat);
        @(negedge clk);
        we_i = 1'b1; addr_i = 32'h300; size_i = 2'b10; unsigned_i = 1'b0;
        wdata_i = 32'hCAFEF00D; req_i = 1'b1;
        @(posedge clk);
        #1 req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready_o, hold_o, rvalid_o} !== 3'b100) begin
            errors++;
            $display("FAIL midop_reset got rdy/hold/rv=%b expected 100",
                     {ready_o, hold_o, rvalid_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rvalid_o) seen++;
        end
        checks++;
        if (seen !== 0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midop_no_resp got rvalid_count=%0d ready=%b expected 0 1",
                     seen, ready_o);
        end
        do_access(1'b0, 32'h300, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11223344 || lat !== LAT) begin
            errors++;
            $display("FAIL midop_mem got rdata=%h lat=%0d expected 11223344 lat=%0d",
                     rd, lat, LAT);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_i      = 1'b0;
        we_i       = 1'b0;
        addr_i     = 32'd0;
        size_i     = 2'b00;
        unsigned_i = 1'b0;
        wdata_i    = 32'd0;
        test_reset();
        test_word();
        test_back_to_back();
        test_misalign();
        test_byte_lanes();
        test_halfword();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
